// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants, per-axis timing struct, clear-FSM states and helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package vga_pkg;

  // Default 640x480 @ 60 Hz timing
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  // One axis of the raster, in order display, front porch, sync, back porch
  typedef struct packed {
    logic [15:0] display;
    logic [15:0] front;
    logic [15:0] sync;
    logic [15:0] back;
  } vga_axis_t;

  typedef enum logic {
    CLEAR,
    IDLE
  } clr_state_t;

  function automatic int axis_total(input vga_axis_t ax);
    return int'(ax.display) + int'(ax.front) + int'(ax.sync) + int'(ax.back);
  endfunction

  // True when pos lies in [display+front, display+front+sync-1]
  function automatic logic in_sync_window(input logic [15:0] pos, input logic [15:0] display,
                                          input logic [15:0] front, input logic [15:0] sync_w);
    logic [15:0] start_pos;
    logic [15:0] end_pos;
    start_pos = display + front;
    end_pos   = start_pos + sync_w;
    return (pos >= start_pos) && (pos < end_pos);
  endfunction

endpackage

// File: rtl/vga_tile_scanout_if.sv
// vga_tile_scanout_if: CPU cell-buffer bus (write/read strobes, address, data, read valid, busy).
// Latency: read_valid/read_data one cycle after an accepted mem_read.
// Backpressure: none; busy signals that writes are being dropped.
// Modports: master = CPU side, slave = scan-out block side.
interface vga_tile_scanout_if #(
  parameter int ADDR_W = 16
);
  logic              mem_write;
  logic              mem_read;
  logic [ADDR_W-1:0] address;
  logic [7:0]        write_data;
  logic [7:0]        read_data;
  logic              read_valid;
  logic              busy;

  modport master (
    output mem_write, mem_read, address, write_data,
    input  read_data, read_valid, busy
  );

  modport slave (
    input  mem_write, mem_read, address, write_data,
    output read_data, read_valid, busy
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: h/v raster counters with sync/visible flags, vblank and frame counting.
// Latency: flags are combinational from the counters; frame_start is registered on the wrap edge.
// Backpressure: none, free-running.
// Ports: clk/reset in; h_cnt/v_cnt, hsync_act/vsync_act (active-high), visible, vblank,
//        frame_start, frame_count out.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int CNT_W     = 10
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             hsync_act,
  output logic             vsync_act,
  output logic             visible,
  output logic             vblank,
  output logic             frame_start,
  output logic [15:0]      frame_count
);

  localparam vga_axis_t H_AX = '{display: 16'(H_DISPLAY), front: 16'(H_FRONT),
                                 sync: 16'(H_SYNC), back: 16'(H_BACK)};
  localparam vga_axis_t V_AX = '{display: 16'(V_DISPLAY), front: 16'(V_FRONT),
                                 sync: 16'(V_SYNC), back: 16'(V_BACK)};
  localparam int H_TOTAL = axis_total(H_AX);
  localparam int V_TOTAL = axis_total(V_AX);

  logic h_last;
  logic v_last;

  assign h_last = (h_cnt == CNT_W'(H_TOTAL - 1));
  assign v_last = (v_cnt == CNT_W'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_start <= 1'b0;
      if (h_last) begin
        h_cnt <= '0;
        if (v_last) begin
          v_cnt       <= '0;
          frame_start <= 1'b1;
          frame_count <= frame_count + 16'd1;
        end else begin
          v_cnt <= v_cnt + 1'b1;
        end
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    hsync_act = in_sync_window(16'(h_cnt), H_AX.display, H_AX.front, H_AX.sync);
    vsync_act = in_sync_window(16'(v_cnt), V_AX.display, V_AX.front, V_AX.sync);
    visible   = (32'(h_cnt) < 32'(H_DISPLAY)) && (32'(v_cnt) < 32'(V_DISPLAY));
    vblank    = (32'(v_cnt) >= 32'(V_DISPLAY));
  end

endmodule

// File: rtl/vga_tile_scanout.sv
// vga_tile_scanout: tile-buffer VGA scan-out with CPU cell port and post-reset clear sequencer.
// Latency: video outputs trail the timing counters by 2 cycles; CPU read data after 1 cycle.
// Backpressure: none; writes dropped while busy or out of range, reads always accepted.
// Ports: clk/reset; cpu slave bus (mem_write/mem_read/address/write_data -> read_data/read_valid/busy);
//        video hsync/vsync/rgb/video_on/pixel_x/pixel_y; status vblank/frame_start/frame_count.
module vga_tile_scanout
  import vga_pkg::*;
#(
  parameter int H_DISPLAY  = DEF_H_DISPLAY,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_DISPLAY  = DEF_V_DISPLAY,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 0,
  parameter int CELL_SHIFT = 3,
  parameter int COLOR_W    = 3,
  parameter int ADDR_W     = 16,
  parameter int CNT_W      = 10
) (
  input  logic               clk,
  input  logic               reset,
  vga_tile_scanout_if.slave  cpu,
  output logic               hsync,
  output logic               vsync,
  output logic [COLOR_W-1:0] rgb,
  output logic               video_on,
  output logic [CNT_W-1:0]   pixel_x,
  output logic [CNT_W-1:0]   pixel_y,
  output logic               vblank,
  output logic               frame_start,
  output logic [15:0]        frame_count
);

  localparam int COLS    = H_DISPLAY >> CELL_SHIFT;
  localparam int ROWS    = V_DISPLAY >> CELL_SHIFT;
  localparam int CELLS   = COLS * ROWS;
  localparam int CELL_AW = (CELLS > 1) ? $clog2(CELLS) : 1;

  // ---------------- S0: raster timing ----------------
  logic [CNT_W-1:0] t_h;
  logic [CNT_W-1:0] t_v;
  logic             t_hs;
  logic             t_vs;
  logic             t_vis;

  vga_timing_gen #(
    .H_DISPLAY (H_DISPLAY),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_DISPLAY (V_DISPLAY),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK),
    .CNT_W     (CNT_W)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .h_cnt       (t_h),
    .v_cnt       (t_v),
    .hsync_act   (t_hs),
    .vsync_act   (t_vs),
    .visible     (t_vis),
    .vblank      (vblank),
    .frame_start (frame_start),
    .frame_count (frame_count)
  );

  // ---------------- frame buffer ----------------
  logic [7:0] mem [0:CELLS-1];

  logic [ADDR_W-1:0]  cpu_addr;
  logic               addr_ok;
  logic [CELL_AW-1:0] cpu_cell;

  assign cpu_addr = cpu.address;
  assign addr_ok  = (32'(cpu_addr) < 32'(CELLS));
  assign cpu_cell = cpu_addr[CELL_AW-1:0];

  // ---------------- clear sequencer ----------------
  clr_state_t         state;
  logic [CELL_AW-1:0] clr_ptr;
  logic               busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      busy_q  <= 1'b1;
    end else if (state == CLEAR) begin
      if (clr_ptr == CELL_AW'(CELLS - 1)) begin
        state   <= IDLE;
        clr_ptr <= '0;
        busy_q  <= 1'b0;
      end else begin
        clr_ptr <= clr_ptr + 1'b1;
      end
    end else begin
      busy_q <= 1'b0;
    end
  end

  // Port A write: the clear sequencer owns the port while clearing, CPU writes are dropped
  logic               ram_we;
  logic [CELL_AW-1:0] ram_waddr;
  logic [7:0]         ram_wdata;

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = cpu_cell;
    ram_wdata = cpu.write_data;
    if (!reset) begin
      if (state == CLEAR) begin
        ram_we    = 1'b1;
        ram_waddr = clr_ptr;
        ram_wdata = 8'h00;
      end else if (cpu.mem_write && addr_ok) begin
        ram_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
  end

  // Port A read: old data on a same-cycle write (read-before-write)
  logic [7:0] rd_q;
  logic       rv_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= 8'h00;
      rv_q <= 1'b0;
    end else begin
      rv_q <= cpu.mem_read;
      if (cpu.mem_read) begin
        rd_q <= (addr_ok && !busy_q) ? mem[cpu_cell] : 8'h00;
      end
    end
  end

  assign cpu.read_data  = rd_q;
  assign cpu.read_valid = rv_q;
  assign cpu.busy       = busy_q;

  // ---------------- S1: cell address and delayed flags ----------------
  logic [CELL_AW-1:0] s1_addr;
  logic [CNT_W-1:0]   s1_x;
  logic [CNT_W-1:0]   s1_y;
  logic               s1_hs;
  logic               s1_vs;
  logic               s1_vis;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_addr <= '0;
      s1_x    <= '0;
      s1_y    <= '0;
      s1_hs   <= 1'b0;
      s1_vs   <= 1'b0;
      s1_vis  <= 1'b0;
    end else begin
      s1_hs  <= t_hs;
      s1_vs  <= t_vs;
      s1_vis <= t_vis;
      s1_x   <= t_vis ? t_h : '0;
      s1_y   <= t_vis ? t_v : '0;
      // Blanking parks the address at 0 so port B never reads past the array
      s1_addr <= t_vis ? CELL_AW'(((32'(t_v) >> CELL_SHIFT) * 32'(COLS)) + (32'(t_h) >> CELL_SHIFT))
                       : '0;
    end
  end

  // ---------------- S2: RAM data and output flags ----------------
  logic [COLOR_W-1:0] s2_pix;
  logic [CNT_W-1:0]   s2_x;
  logic [CNT_W-1:0]   s2_y;
  logic               s2_hs;
  logic               s2_vs;
  logic               s2_vis;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_pix <= '0;
      s2_x   <= '0;
      s2_y   <= '0;
      s2_hs  <= 1'b0;
      s2_vs  <= 1'b0;
      s2_vis <= 1'b0;
    end else begin
      s2_pix <= mem[s1_addr][COLOR_W-1:0];
      s2_x   <= s1_x;
      s2_y   <= s1_y;
      s2_hs  <= s1_hs;
      s2_vs  <= s1_vs;
      s2_vis <= s1_vis;
    end
  end

  assign hsync    = (HSYNC_POL != 0) ? s2_hs : ~s2_hs;
  assign vsync    = (VSYNC_POL != 0) ? s2_vs : ~s2_vs;
  assign video_on = s2_vis;
  assign pixel_x  = s2_x;
  assign pixel_y  = s2_y;
  assign rgb      = (s2_vis && !busy_q) ? s2_pix : '0;

endmodule

// File: tb/tb_vga_tile_scanout.sv
// tb_vga_tile_scanout: directed bench for two scan-out instances on a reduced 160x76 raster.
// Instance A: active-low syncs, 8x8 cells, 3-bit colour. Instance B: active-high hsync, 16x16 cells, 8-bit colour.
// Expected values are hand-derived from the raster geometry and the cells written.
module tb_vga_tile_scanout;

  localparam int HT    = 160;   // 128 + 8 + 16 + 8
  localparam int VT    = 76;    // 64 + 4 + 3 + 5
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vga_tile_scanout_if #(.ADDR_W(16)) cpu_a ();
  vga_tile_scanout_if #(.ADDR_W(16)) cpu_b ();

  logic       a_hsync, a_vsync, a_video_on, a_vblank, a_frame_start;
  logic [2:0] a_rgb;
  logic [9:0] a_pixel_x, a_pixel_y;
  logic [15:0] a_frame_count;
  logic       b_hsync, b_vsync, b_video_on, b_vblank, b_frame_start;
  logic [7:0] b_rgb;
  logic [9:0] b_pixel_x, b_pixel_y;
  logic [15:0] b_frame_count;

  vga_tile_scanout #(
    .H_DISPLAY(128), .H_FRONT(8), .H_SYNC(16), .H_BACK(8),
    .V_DISPLAY(64), .V_FRONT(4), .V_SYNC(3), .V_BACK(5),
    .HSYNC_POL(0), .VSYNC_POL(0), .CELL_SHIFT(3), .COLOR_W(3), .ADDR_W(16), .CNT_W(10)
  ) dut_a (
    .clk(clk), .reset(reset), .cpu(cpu_a),
    .hsync(a_hsync), .vsync(a_vsync), .rgb(a_rgb), .video_on(a_video_on),
    .pixel_x(a_pixel_x), .pixel_y(a_pixel_y), .vblank(a_vblank),
    .frame_start(a_frame_start), .frame_count(a_frame_count)
  );

  vga_tile_scanout #(
    .H_DISPLAY(128), .H_FRONT(8), .H_SYNC(16), .H_BACK(8),
    .V_DISPLAY(64), .V_FRONT(4), .V_SYNC(3), .V_BACK(5),
    .HSYNC_POL(1), .VSYNC_POL(0), .CELL_SHIFT(4), .COLOR_W(8), .ADDR_W(16), .CNT_W(10)
  ) dut_b (
    .clk(clk), .reset(reset), .cpu(cpu_b),
    .hsync(b_hsync), .vsync(b_vsync), .rgb(b_rgb), .video_on(b_video_on),
    .pixel_x(b_pixel_x), .pixel_y(b_pixel_y), .vblank(b_vblank),
    .frame_start(b_frame_start), .frame_count(b_frame_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Cycles since reset release: between edges, the S0 counters sit at raster position cyc
  int cyc;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int busy_a_cycles = 0;
  int busy_b_cycles = 0;
  int fs_cyc[$];
  always @(negedge clk) begin
    if (!reset) begin
      if (cpu_a.busy) busy_a_cycles++;
      if (cpu_b.busy) busy_b_cycles++;
      if (a_frame_start) fs_cyc.push_back(cyc);
    end
  end

  // One CPU bus cycle on instance sel (0 = A, 1 = B); returns the response sampled the cycle after
  task automatic cpu_op(input bit sel, input bit rd, input bit wr, input logic [15:0] a,
                        input logic [7:0] wd, output logic [7:0] rdata, output logic rvalid);
    @(posedge clk); #1;
    if (sel) begin
      cpu_b.mem_read = rd; cpu_b.mem_write = wr; cpu_b.address = a; cpu_b.write_data = wd;
    end else begin
      cpu_a.mem_read = rd; cpu_a.mem_write = wr; cpu_a.address = a; cpu_a.write_data = wd;
    end
    @(posedge clk); #1;
    cpu_a.mem_read = 1'b0; cpu_a.mem_write = 1'b0;
    cpu_b.mem_read = 1'b0; cpu_b.mem_write = 1'b0;
    @(negedge clk);
    rdata  = sel ? cpu_b.read_data : cpu_a.read_data;
    rvalid = sel ? cpu_b.read_valid : cpu_a.read_valid;
  endtask

  initial begin
    logic [7:0] rd;
    logic       rv;
    int h, v;
    int vid_cnt, hs_first, hs_len, bhs_first, bhs_len, vs_first, vs_cnt, vb_cnt;
    int rgb5_cnt, a5_cnt, xy_bad, vis_bad;

    cpu_a.mem_read = 1'b0; cpu_a.mem_write = 1'b0; cpu_a.address = '0; cpu_a.write_data = '0;
    cpu_b.mem_read = 1'b0; cpu_b.mem_write = 1'b0; cpu_b.address = '0; cpu_b.write_data = '0;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_hsync", a_hsync, 1);
    check("rst_b_hsync", b_hsync, 0);
    check("rst_a_vsync", a_vsync, 1);
    check("rst_a_video_on", a_video_on, 0);
    check("rst_a_rgb", a_rgb, 0);
    check("rst_a_pixel_xy", {a_pixel_x, a_pixel_y}, 0);
    check("rst_a_read", {cpu_a.read_valid, cpu_a.read_data}, 0);
    check("rst_a_frame", {a_frame_start, a_frame_count}, 0);
    check("rst_a_busy", cpu_a.busy, 1);
    @(posedge clk); #1;
    reset = 1'b0;

    // ---- accesses during clear ----
    cpu_op(0, 1, 0, 16'd100, 8'h00, rd, rv);
    check("clr_read_valid", rv, 1);
    check("clr_read_data", rd, 8'h00);
    @(negedge clk);
    check("read_valid_pulse", cpu_a.read_valid, 0);
    // cell 2 is already behind the clear pointer, so an accepted write would persist
    cpu_op(0, 0, 1, 16'd2, 8'hFF, rd, rv);
    for (int i = 0; i < 1000 && (cpu_a.busy || cpu_b.busy); i++) @(negedge clk);
    check("busy_len_a", busy_a_cycles, 128);
    check("busy_len_b", busy_b_cycles, 32);
    cpu_op(0, 1, 0, 16'd2, 8'h00, rd, rv);
    check("clr_write_dropped", rd, 8'h00);

    // ---- CPU port after clear ----
    cpu_op(0, 0, 1, 16'd0, 8'h05, rd, rv);
    cpu_op(0, 0, 1, 16'd2, 8'h03, rd, rv);
    cpu_op(0, 0, 1, 16'd16, 8'hFE, rd, rv);
    cpu_op(0, 0, 1, 16'd128, 8'h07, rd, rv);
    cpu_op(0, 1, 0, 16'd128, 8'h00, rd, rv);
    check("oor_read", {rv, rd}, {1'b1, 8'h00});
    cpu_op(0, 1, 0, 16'd0, 8'h00, rd, rv);
    check("oor_write_no_alias", rd, 8'h05);
    cpu_op(0, 0, 1, 16'd10, 8'h01, rd, rv);
    cpu_op(0, 1, 1, 16'd10, 8'h02, rd, rv);
    check("rbw_old", rd, 8'h01);
    cpu_op(0, 1, 0, 16'd10, 8'h00, rd, rv);
    check("rbw_new", rd, 8'h02);
    cpu_op(1, 0, 1, 16'd1, 8'hA5, rd, rv);
    cpu_op(1, 0, 1, 16'd8, 8'h3C, rd, rv);
    cpu_op(1, 1, 0, 16'd1, 8'h00, rd, rv);
    check("b_read", rd, 8'hA5);
    cpu_op(1, 1, 0, 16'd40, 8'h00, rd, rv);
    check("b_oor_read", {rv, rd}, {1'b1, 8'h00});

    // ---- scan frame 1; outputs at cyc show raster position cyc-2 ----
    vid_cnt = 0; hs_first = -1; hs_len = 0; bhs_first = -1; bhs_len = 0;
    vs_first = -1; vs_cnt = 0; vb_cnt = 0; rgb5_cnt = 0; a5_cnt = 0; xy_bad = 0; vis_bad = 0;
    while (cyc != FRAME + 2) @(negedge clk);
    for (int i = 0; i < FRAME; i++) begin
      h = i % HT;
      v = i / HT;
      if (a_video_on !== ((h < 128) && (v < 64))) vis_bad++;
      if (a_video_on && (int'(a_pixel_x) != h || int'(a_pixel_y) != v)) xy_bad++;
      if (!a_video_on && (a_pixel_x != 0 || a_pixel_y != 0 || a_rgb != 0)) xy_bad++;
      if (a_video_on) vid_cnt++;
      if (v == 0 && !a_hsync) begin if (hs_first < 0) hs_first = h; hs_len++; end
      if (v == 0 && b_hsync) begin if (bhs_first < 0) bhs_first = h; bhs_len++; end
      if (!a_vsync) begin if (vs_first < 0) vs_first = i; vs_cnt++; end
      if (a_vblank) vb_cnt++;
      if (a_rgb == 3'd5) rgb5_cnt++;
      if (b_rgb == 8'hA5) a5_cnt++;
      if (h == 0 && v == 0) begin
        check("a_px_0_0_rgb", a_rgb, 3'd5);
        check("a_px_0_0_vid", a_video_on, 1);
      end
      if (h == 7 && v == 7) check("a_px_7_7", {a_rgb, a_pixel_x, a_pixel_y}, {3'd5, 10'd7, 10'd7});
      if (h == 8 && v == 0) check("a_px_8_0_rgb", a_rgb, 3'd0);
      if (h == 16 && v == 3) check("a_px_16_3_rgb", a_rgb, 3'd3);
      if (h == 0 && v == 8) check("a_px_0_8_rgb_trunc", a_rgb, 3'd6);
      if (h == 80 && v == 0) check("a_px_80_0_rgb", a_rgb, 3'd2);
      if (h == 127 && v == 63) check("a_px_last", {a_video_on, a_pixel_x, a_pixel_y}, {1'b1, 10'd127, 10'd63});
      if (h == 128 && v == 0) check("a_px_128_0_blank", {a_video_on, a_rgb}, 0);
      if (h == 15 && v == 0) check("b_px_15_0", b_rgb, 8'h00);
      if (h == 16 && v == 0) check("b_px_16_0", b_rgb, 8'hA5);
      if (h == 31 && v == 15) check("b_px_31_15", b_rgb, 8'hA5);
      if (h == 32 && v == 0) check("b_px_32_0", b_rgb, 8'h00);
      if (h == 0 && v == 16) check("b_px_0_16", b_rgb, 8'h3C);
      @(negedge clk);
    end
    check("a_visible_map", vis_bad, 0);
    check("a_pixel_xy_align", xy_bad, 0);
    check("a_video_on_count", vid_cnt, 128 * 64);
    check("a_hsync_first", hs_first, 136);
    check("a_hsync_len", hs_len, 16);
    check("b_hsync_first", bhs_first, 136);
    check("b_hsync_len", bhs_len, 16);
    check("a_vsync_first", vs_first, 68 * HT);
    check("a_vsync_cycles", vs_cnt, 3 * HT);
    check("a_vblank_cycles", vb_cnt, 12 * HT);
    check("a_rgb5_pixels", rgb5_cnt, 64);
    check("b_a5_pixels", a5_cnt, 256);

    // ---- frame pulses over three frames ----
    while (cyc < 3 * FRAME + 4) @(negedge clk);
    check("frame_pulses", fs_cyc.size(), 3);
    if (fs_cyc.size() >= 3) begin
      check("frame_pulse_0", fs_cyc[0], FRAME);
      check("frame_pulse_gap1", fs_cyc[1] - fs_cyc[0], FRAME);
      check("frame_pulse_gap2", fs_cyc[2] - fs_cyc[1], FRAME);
    end
    check("a_frame_count", a_frame_count, 3);
    check("b_frame_count", b_frame_count, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_tile_scanout.md
Name: vga_tile_scanout

Overview:
- Parametrised successor to the fixed 640x480 tile-buffer VGA controller.
- Generic timing, sync polarity, cell size and colour depth.
- Two-stage registered scan-out pipeline with sync/blank aligned to pixel data, so the frame buffer maps to synchronous block RAM.
- Hardware clear sequencer after reset, registered CPU read port with valid strobe, and frame/vblank status for CPU polling or interrupt.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BACK, 48, horizontal back porch
- V_DISPLAY, 480, visible lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BACK, 33, vertical back porch
- HSYNC_POL, 0, active level of hsync (0 = active low)
- VSYNC_POL, 0, active level of vsync
- CELL_SHIFT, 3, log2 of cell edge in pixels (8x8 cells)
- COLOR_W, 3, rgb width, taken from cell byte bits [COLOR_W-1:0]; must be 1..8
- ADDR_W, 16, CPU address width
- CNT_W, 10, timing counter / pixel coordinate width
- Derived values: H_TOTAL, V_TOTAL, COLS = H_DISPLAY>>CELL_SHIFT, ROWS = V_DISPLAY>>CELL_SHIFT, CELLS = COLS*ROWS (default 4800).

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- mem_write  in  1  CPU write strobe
- mem_read  in  1  CPU read strobe
- address  in  ADDR_W  cell index
- write_data  in  8  cell byte
- read_data  out  8  registered read data
- read_valid  out  1  one-cycle pulse, one cycle after an accepted mem_read
- busy  out  1  clear sequencer active
- hsync  out  1  horizontal sync, polarity per HSYNC_POL
- vsync  out  1  vertical sync, polarity per VSYNC_POL
- rgb  out  COLOR_W  pixel colour
- video_on  out  1  rgb is a visible pixel
- pixel_x  out  CNT_W  x of pixel on rgb; 0 when not visible
- pixel_y  out  CNT_W  y of pixel on rgb; 0 when not visible
- vblank  out  1  v counter >= V_DISPLAY (counter-stage, undelayed)
- frame_start  out  1  one-cycle pulse on frame wrap
- frame_count  out  16  frames completed since reset

Behaviour:
- Line/frame order is display, front porch, sync, back porch. Counter value 0 is the first visible pixel.
- h counts 0..H_TOTAL-1 and wraps. v increments when h wraps, counts 0..V_TOTAL-1 and wraps.
- Sync is active for h in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1]; likewise for v.
- Pipeline:
  - S0: counters.
  - S1: registered cell address (v>>CELL_SHIFT)*COLS + (h>>CELL_SHIFT), plus delayed h, v, sync and visible flags.
  - S2: registered RAM data plus delayed flags driving the outputs.
  - hsync, vsync, video_on, pixel_x, pixel_y and rgb are mutually aligned and lag the S0 counters by exactly 2 cycles.
- rgb = 0 whenever video_on = 0 or busy = 1.
- frame_start pulses for one cycle when the S0 counters go from (H_TOTAL-1, V_TOTAL-1) to (0,0). frame_count increments on the same edge and wraps 0xFFFF -> 0. No pulse at reset release.
- Reset values:
  - Counters 0, all pipeline registers cleared.
  - hsync = !HSYNC_POL, vsync = !VSYNC_POL.
  - rgb, video_on, pixel_x, pixel_y, read_data, read_valid, frame_start, frame_count all 0.
  - busy = 1 in the first cycle after reset deasserts.
- Clear FSM, states CLEAR and IDLE:
  - Reset forces CLEAR with pointer 0.
  - CLEAR writes 8'h00 to cell pointer, one cell per cycle, so it lasts exactly CELLS cycles. After the last cell it goes to IDLE and busy drops.
  - Reset during CLEAR restarts from pointer 0.
  - Scan-out timing runs normally during CLEAR.
- CPU port:
  - In IDLE, a write is accepted when address < CELLS; otherwise it is ignored.
  - During CLEAR, writes are dropped.
  - A read is always accepted. read_valid = 1 next cycle, with read_data = cell contents, or 8'h00 if address >= CELLS or busy.
  - Simultaneous read and write to the same address returns the old data (read-before-write).
  - CPU writes are visible to scan-out from the following cycle; no tearing protection.
- Frame buffer: one RAM, CELLS x 8. CPU read/write on port A, scan-out read on port B. No reset clear of the array other than the FSM.

Decomposition:
- Shared package vga_pkg holds:
  - default 640x480 timing constants;
  - a timing-parameter struct typedef;
  - a helper function computing the sync-active window.
- Natural sub-module: vga_timing_gen (h/v counters, sync/visible flags, vblank, frame_start, frame_count), reused by future display blocks.
- RAM is inferred inline.

Test Plan:
- Reset then idle -> busy high for exactly 4800 cycles. A read of address 100 during clear returns read_valid = 1 with data 8'h00. A write of 8'hFF to address 5 during clear, then a read after clear, returns 8'h00.
- After clear, write 8'h05 to address 0 -> at counter (0,0)+2 cycles, video_on = 1, pixel_x = 0, rgb = 3'b101 for 8 pixels on lines 0-7; pixel_x = 8 shows 3'b000.
- Defaults -> hsync low for 96 cycles, starting 658 cycles after h = 0. vsync low for 2 lines starting at line 490 (+2 cycles). Video_on high 640 of 800 cycles per line.
- Write address 4800 with 8'h07, read 4800 -> no RAM change, read_valid = 1 with data 8'h00. Same-cycle read and write of address 10 (old 8'h01, new 8'h02) -> read_data 8'h01; the next read returns 8'h02.
- Run 3 frames -> frame_start pulses 3 times, 420000 cycles apart. frame_count = 3. vblank high for 45 lines per frame.
- Reparametrise HSYNC_POL = 1, CELL_SHIFT = 4, COLOR_W = 8 -> hsync active-high. Cell 1 covers x 16..31. rgb equals the full written byte.
